// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes and
// datapath mux/ALU select codes used by the controller and its ALU decoder.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTER = 4'd7,
        S_EXECUTEI = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    // Instruction class presented to the ALU decoder
    typedef enum logic [1:0] {
        CLS_R  = 2'd0,
        CLS_I  = 2'd1,
        CLS_BR = 2'd2
    } op_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath/memory bundle. master = control FSM, slave = datapath.
interface multicycle_control_fsm_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic [DATA_WIDTH-1:0] instr;
    logic                  EQ;
    logic                  mem_ready;
    logic                  mem_req;
    logic                  MemWrite;
    logic                  AdrSrc;
    logic                  IRWrite;
    logic                  PCWrite;
    logic                  RegWrite;
    logic [1:0]            ResultSrc;
    logic [1:0]            ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [2:0]            ImmSrc;
    logic [2:0]            ALUctrl;
    logic                  illegal_instr;
    logic [CNT_WIDTH-1:0]  instr_retired;

    modport master (
        input  instr, EQ, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUctrl,
               illegal_instr, instr_retired
    );

    modport slave (
        output instr, EQ, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUctrl,
               illegal_instr, instr_retired
    );
endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Combinational ALU operation decode from instruction class, funct3 and instr[30];
// legal=0 flags a funct3 this subset does not implement.
module alu_decoder
    import ctrl_pkg::*;
(
    input  op_class_t  op_class,
    input  logic [2:0] funct3,
    input  logic       bit30,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
        if (op_class == CLS_BR) begin
            // beq/bne both compare by subtraction; EQ comes from the result
            alu_ctrl = ALU_SUB;
            legal    = (funct3 == 3'b000) || (funct3 == 3'b001);
        end else begin
            case (funct3)
                3'b000: begin
                    legal    = 1'b1;
                    alu_ctrl = (op_class == CLS_R && bit30) ? ALU_SUB : ALU_ADD;
                end
                3'b010: begin
                    legal    = 1'b1;
                    alu_ctrl = ALU_SLT;
                end
                3'b110: begin
                    legal    = 1'b1;
                    alu_ctrl = ALU_OR;
                end
                3'b111: begin
                    legal    = 1'b1;
                    alu_ctrl = ALU_AND;
                end
                default: begin
                    legal    = 1'b0;
                    alu_ctrl = ALU_ADD;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I-subset controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing,
// memory waits on mem_ready, sticky illegal-instruction trap and retired-instruction count.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic clk,
    input  logic rst,
    multicycle_control_fsm_if.master bus
);

    state_t               state_q, state_d;
    logic                 retire;
    logic                 illegal_q;
    logic [CNT_WIDTH-1:0] retired_q;
    op_class_t            op_class;
    logic [2:0]           dec_alu;
    logic                 dec_legal;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 unused_instr_bits;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign unused_instr_bits = ^{bus.instr[DATA_WIDTH-1:31], bus.instr[29:15], bus.instr[11:7]};

    always_comb begin
        case (state_q)
            S_BRANCH:   op_class = CLS_BR;
            S_EXECUTEI: op_class = CLS_I;
            default:    op_class = CLS_R;
        endcase
    end

    alu_decoder u_alu_decoder (
        .op_class (op_class),
        .funct3   (funct3),
        .bit30    (bus.instr[30]),
        .alu_ctrl (dec_alu),
        .legal    (dec_legal)
    );

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        bus.mem_req   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.PCWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RS2;
        bus.ImmSrc    = IMM_NONE;
        bus.ALUctrl   = ALU_ADD;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALU;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target OldPC+immB is precomputed here into ALUOut
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                if (opcode == OP_STORE) begin
                    bus.ImmSrc = IMM_S;
                    state_d    = S_MEMWRITE;
                end else begin
                    bus.ImmSrc = IMM_I;
                    state_d    = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.AdrSrc  = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.RegWrite  = 1'b1;
                bus.ResultSrc = RES_MEM;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.mem_req  = 1'b1;
                bus.MemWrite = 1'b1;
                bus.AdrSrc   = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER, S_EXECUTEI: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = (state_q == S_EXECUTEI) ? SRCB_IMM : SRCB_RS2;
                bus.ImmSrc  = (state_q == S_EXECUTEI) ? IMM_I : IMM_NONE;
                bus.ALUctrl = dec_alu;
                state_d     = dec_legal ? S_ALUWB : S_TRAP;
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_RS2;
                bus.ALUctrl = dec_alu;
                bus.PCWrite = ((funct3 == 3'b000) && bus.EQ) ||
                              ((funct3 == 3'b001) && !bus.EQ);
                if (dec_legal) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_JAL: begin
                // PC takes the DECODE target while OldPC+4 is formed for rd
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                bus.PCWrite = 1'b1;
                state_d     = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == S_TRAP);
            if (retire) retired_q <= retired_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign bus.illegal_instr = illegal_q;
    assign bus.instr_retired = retired_q;

endmodule
